// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte accept, 11-bit frame shifter, bit-time and frame counters.
// Define UART_TX_PARITY_EN to send a parity bit in position 9; otherwise a second stop bit is sent.

module uart_tx_ctrl #(
   parameter int unsigned BAUD_W = 19
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [7:0]        din,
   input  logic [BAUD_W-1:0] baud_k,
   input  logic              odd_n_even,
   output logic              tx,
   output logic              tx_rdy,
   output logic              busy
);

   localparam int unsigned FRAME_LEN = 11;
   localparam int unsigned FCNT_W    = 4;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [BAUD_W-1:0] K_MIN    = BAUD_W'(2);
   localparam logic [FCNT_W-1:0] LAST_BIT = FCNT_W'(FRAME_LEN - 1);

   logic [1:0]           state,  state_nxt;
   logic [FRAME_LEN-1:0] shreg,  shreg_nxt;
   logic [BAUD_W-1:0]    bcnt,   bcnt_nxt;
   logic [BAUD_W-1:0]    k_lat,  k_nxt;
   logic [FCNT_W-1:0]    fcnt,   fcnt_nxt;
   logic                 doit,   doit_nxt;
   logic                 rdy_q,  rdy_nxt;
   logic                 btu;
   logic                 bit9;

`ifdef UART_TX_PARITY_EN
   assign bit9 = (^din) ^ odd_n_even;
`else
   logic unused_odd_n_even;
   assign bit9              = 1'b1;
   assign unused_odd_n_even = odd_n_even;
`endif

   // One bit time elapsed; k_lat is never below 2 so the subtraction cannot wrap
   assign btu = doit && (bcnt == (k_lat - BAUD_W'(1)));

   // Next-state and datapath decode
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      k_nxt     = k_lat;
      fcnt_nxt  = fcnt;
      doit_nxt  = doit;
      rdy_nxt   = rdy_q;
      if (!doit || btu) bcnt_nxt = '0;
      else              bcnt_nxt = bcnt + BAUD_W'(1);

      case (state)
         IDLE: begin
            doit_nxt = 1'b0;
            rdy_nxt  = 1'b1;
            fcnt_nxt = '0;
            if (load) begin
               k_nxt     = (baud_k < K_MIN) ? K_MIN : baud_k;
               shreg_nxt = {1'b1, bit9, din, 1'b0};
               doit_nxt  = 1'b1;
               rdy_nxt   = 1'b0;
               bcnt_nxt  = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (btu) begin
               shreg_nxt = {1'b1, shreg[FRAME_LEN-1:1]};
               fcnt_nxt  = fcnt + FCNT_W'(1);
               // Counter reaching 11 on this edge means the stop bit just finished
               if (fcnt == LAST_BIT) state_nxt = DONE;
            end
         end
         DONE: begin
            doit_nxt  = 1'b0;
            bcnt_nxt  = '0;
            fcnt_nxt  = '0;
            rdy_nxt   = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            shreg_nxt = '1;
            doit_nxt  = 1'b0;
            bcnt_nxt  = '0;
            fcnt_nxt  = '0;
            rdy_nxt   = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         shreg <= '1;
         bcnt  <= '0;
         k_lat <= K_MIN;
         fcnt  <= '0;
         doit  <= 1'b0;
         rdy_q <= 1'b1;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         bcnt  <= bcnt_nxt;
         k_lat <= k_nxt;
         fcnt  <= fcnt_nxt;
         doit  <= doit_nxt;
         rdy_q <= rdy_nxt;
      end
   end

   assign tx     = shreg[0];
   assign tx_rdy = rdy_q;
   assign busy   = doit;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: vector table, corner sequences and random traffic against a timeline model.

module tb_uart_tx_ctrl;

   localparam int unsigned BAUD_W = 19;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              load;
   logic [7:0]        din;
   logic [BAUD_W-1:0] baud_k;
   logic              odd_n_even;
   logic              tx;
   logic              tx_rdy;
   logic              busy;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.BAUD_W(BAUD_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .din        (din),
      .baud_k     (baud_k),
      .odd_n_even (odd_n_even),
      .tx         (tx),
      .tx_rdy     (tx_rdy),
      .busy       (busy)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: time since accept, latched K and the frame bits to emit
   bit          m_active;
   int          m_t;
   int          m_k;
   logic [10:0] m_bits;

   typedef struct {
      logic [7:0]        din;
      logic              odd;
      logic [BAUD_W-1:0] k;
      logic              exp_p;
      int                exp_rise;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic ref_bit9(input logic [7:0] d, input logic o);
      int   ones;
      logic unused_o;
      ones     = 0;
      unused_o = o;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
`ifdef UART_TX_PARITY_EN
      return logic'(ones % 2) ^ o;
`else
      return (ones >= 0) ? 1'b1 : unused_o;
`endif
   endfunction

   // Advance one clock, update the model from the inputs seen at the edge, then compare
   task automatic step();
      logic e_tx, e_rdy, e_busy;
      @(posedge clk);
      if (!reset_n) begin
         m_active = 1'b0;
      end else if ((!m_active || m_t >= 11 * m_k + 1) && load === 1'b1) begin
         m_active = 1'b1;
         m_t      = 0;
         m_k      = (int'(baud_k) < 2) ? 2 : int'(baud_k);
         m_bits   = {1'b1, ref_bit9(din, odd_n_even), din, 1'b0};
      end else if (m_active) begin
         m_t++;
      end
      if (!m_active || m_t > 11 * m_k) begin
         e_tx = 1'b1; e_rdy = 1'b1; e_busy = 1'b0;
      end else if (m_t < 11 * m_k) begin
         e_tx = m_bits[m_t / m_k]; e_rdy = 1'b0; e_busy = 1'b1;
      end else begin
         e_tx = 1'b1; e_rdy = 1'b0; e_busy = 1'b1;
      end
      #1;
      chk("tx",     32'(tx),     32'(e_tx));
      chk("tx_rdy", 32'(tx_rdy), 32'(e_rdy));
      chk("busy",   32'(busy),   32'(e_busy));
   endtask

   initial begin
      int   rise;
      int   kc;
      int   nrise;
      logic par;
      logic exp9;
      logic prev_busy;
      int   acc[$];

      vecs[0] = '{8'hA5, 1'b0, BAUD_W'(4), 1'b0, 45};
      vecs[1] = '{8'h07, 1'b1, BAUD_W'(3), 1'b0, 34};
      vecs[2] = '{8'h07, 1'b0, BAUD_W'(3), 1'b1, 34};
      vecs[3] = '{8'h00, 1'b1, BAUD_W'(0), 1'b1, 23};
      vecs[4] = '{8'hFF, 1'b0, BAUD_W'(1), 1'b0, 23};
      vecs[5] = '{8'h81, 1'b1, BAUD_W'(5), 1'b1, 56};

      reset_n    = 1'b0;
      load       = 1'b0;
      din        = 8'h00;
      baud_k     = BAUD_W'(4);
      odd_n_even = 1'b0;
      m_active   = 1'b0;
      m_t        = 0;
      m_k        = 2;
      m_bits     = '1;

      #12;
      chk("reset_tx",     32'(tx),     32'(1));
      chk("reset_tx_rdy", 32'(tx_rdy), 32'(1));
      chk("reset_busy",   32'(busy),   32'(0));
      @(negedge clk);
      reset_n = 1'b1;
      repeat (100) step();

      // Single frames from the vector table
      foreach (vecs[v]) begin
`ifdef UART_TX_PARITY_EN
         exp9 = vecs[v].exp_p;
`else
         exp9 = 1'b1;
`endif
         kc         = (vecs[v].exp_rise - 1) / 11;
         din        = vecs[v].din;
         odd_n_even = vecs[v].odd;
         baud_k     = vecs[v].k;
         load       = 1'b1;
         step();
         load = 1'b0;
         rise = 0;
         par  = 1'bx;
         for (int i = 1; i <= 300 && rise == 0; i++) begin
            step();
            if (i == 9 * kc) par = tx;
            if (tx_rdy === 1'b1) rise = i;
         end
         chk("rdy_rise", 32'(rise), 32'(vecs[v].exp_rise));
         chk("bit9",     32'(par),  32'(exp9));
      end

      // Load while busy is ignored
      din    = 8'h55;
      baud_k = BAUD_W'(3);
      load   = 1'b1;
      step();
      load  = 1'b0;
      nrise = 1;
      prev_busy = busy;
      for (int i = 1; i < 60; i++) begin
         if (i == 10) begin load = 1'b1; din = 8'h3C; end
         if (i == 11) load = 1'b0;
         step();
         if (busy === 1'b1 && prev_busy === 1'b0) nrise++;
         prev_busy = busy;
      end
      chk("busy_load_frames", 32'(nrise), 32'(1));

      // Held load with clamped K and mid-frame input changes
      din       = 8'h5A;
      baud_k    = BAUD_W'(1);
      load      = 1'b1;
      prev_busy = busy;
      for (int i = 0; i < 80; i++) begin
         if (i == 5)  baud_k = BAUD_W'(9);
         if (i == 7)  din = 8'hC3;
         if (i == 10) baud_k = BAUD_W'(1);
         step();
         if (busy === 1'b1 && prev_busy === 1'b0) acc.push_back(i);
         prev_busy = busy;
      end
      load = 1'b0;
      chk("held_frames", 32'(acc.size()), 32'(4));
      for (int j = 1; j < acc.size(); j++)
         chk("held_period", 32'(acc[j] - acc[j-1]), 32'(24));
      repeat (30) step();

      // Reset during data bit 3, then a clean frame
      din    = 8'h96;
      baud_k = BAUD_W'(4);
      load   = 1'b1;
      step();
      load = 1'b0;
      repeat (17) step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_tx",     32'(tx),     32'(1));
      chk("midrst_tx_rdy", 32'(tx_rdy), 32'(1));
      chk("midrst_busy",   32'(busy),   32'(0));
      repeat (2) step();
      reset_n = 1'b1;
      step();
      din    = 8'h3B;
      baud_k = BAUD_W'(3);
      load   = 1'b1;
      step();
      load = 1'b0;
      repeat (40) step();

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         load       = ($urandom_range(0, 7) == 0);
         din        = 8'($urandom);
         odd_n_even = 1'($urandom);
         baud_k     = BAUD_W'($urandom_range(0, 5));
         step();
      end
      load = 1'b0;
      repeat (70) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
